nrzi_symbol_aligner: RTL and testbench



---
 rtl/nrzi_symbol_aligner_if.sv | 21 ++
 rtl/nrzi_symbol_aligner.sv | 154 +++++++++++++++
 tb/tb_nrzi_symbol_aligner.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nrzi_symbol_aligner_if.sv
// Control/status bundle between the deser400 receive path and the symbol aligner.
interface nrzi_symbol_aligner_if;
  logic       enable;
  logic       force_slip;
  logic       dec_error;
  logic [2:0] phase;
  logic       locked;
  logic       slip_pulse;
  logic       lock_lost;
  logic [7:0] slip_count;

  modport master (
    output enable, force_slip, dec_error,
    input  phase, locked, slip_pulse, lock_lost, slip_count
  );

  modport slave (
    input  enable, force_slip, dec_error,
    output phase, locked, slip_pulse, lock_lost, slip_count
  );
endinterface

// File: rtl/nrzi_symbol_aligner.sv
// Steps the deserializer word phase until the 4B5B decoder runs clean, declares lock,
// then watches the windowed error rate and re-hunts when lock is lost.
module nrzi_symbol_aligner #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CHECK_LEN     = 64,
  parameter int LOCK_ERR_MAX  = 0,
  parameter int LOSS_WINDOW   = 256,
  parameter int LOSS_ERR_MAX  = 4
) (
  input  logic                  clk80,
  input  logic                  reset,
  nrzi_symbol_aligner_if.slave  bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(CHECK_LEN + 1);
  localparam int EW = $clog2(LOCK_ERR_MAX + 2);
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int LW = $clog2(LOSS_ERR_MAX + 1);

  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHK_LAST = CW'(CHECK_LEN - 1);
  localparam logic [EW:0]   CHK_MAX  = (EW + 1)'(LOCK_ERR_MAX);
  localparam logic [WW-1:0] WIN_LAST = WW'(LOSS_WINDOW - 1);
  localparam logic [LW:0]   LOSS_MAX = (LW + 1)'(LOSS_ERR_MAX);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCKED} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_set_cnt, w_set_cnt_nxt;
  logic [CW-1:0] r_chk_cnt, w_chk_cnt_nxt;
  logic [EW-1:0] r_chk_err, w_chk_err_nxt;
  logic [WW-1:0] r_win_cnt, w_win_cnt_nxt;
  logic [LW-1:0] r_loss_err, w_loss_err_nxt;
  logic [2:0]    r_phase, w_phase_nxt;
  logic [7:0]    r_slip_count, w_slip_count_nxt;
  logic          r_locked, w_locked_nxt;
  logic          r_slip_pulse, w_slip_pulse_nxt;
  logic          r_lock_lost, w_lock_lost_nxt;

  logic [EW:0]   w_chk_sum;
  logic [LW:0]   w_loss_sum;

  assign w_chk_sum  = {1'b0, r_chk_err} + (EW + 1)'(bus.dec_error);
  assign w_loss_sum = {1'b0, r_loss_err} + (LW + 1)'(bus.dec_error);

  always_comb begin
    w_state_nxt      = r_state;
    w_set_cnt_nxt    = r_set_cnt;
    w_chk_cnt_nxt    = r_chk_cnt;
    w_chk_err_nxt    = r_chk_err;
    w_win_cnt_nxt    = r_win_cnt;
    w_loss_err_nxt   = r_loss_err;
    w_phase_nxt      = r_phase;
    w_slip_count_nxt = r_slip_count;
    w_slip_pulse_nxt = 1'b0;
    w_lock_lost_nxt  = 1'b0;

    // The advance is committed as SLIP is left, so disabling during SLIP holds the phase.
    if (r_state == SLIP && bus.enable) begin
      w_phase_nxt      = (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
      w_slip_pulse_nxt = 1'b1;
      if (r_slip_count != 8'hFF) w_slip_count_nxt = r_slip_count + 8'd1;
    end

    if (!bus.enable) begin
      w_state_nxt    = IDLE;
      w_set_cnt_nxt  = '0;
      w_chk_cnt_nxt  = '0;
      w_chk_err_nxt  = '0;
      w_win_cnt_nxt  = '0;
      w_loss_err_nxt = '0;
    end else if (bus.force_slip && r_state != IDLE) begin
      w_state_nxt = SLIP;
    end else begin
      case (r_state)
        IDLE, SLIP: begin
          w_state_nxt   = SETTLE;
          w_set_cnt_nxt = '0;
        end
        SETTLE: begin
          if (r_set_cnt == SET_LAST) begin
            w_state_nxt   = CHECK;
            w_chk_cnt_nxt = '0;
            w_chk_err_nxt = '0;
          end else begin
            w_set_cnt_nxt = r_set_cnt + SW'(1);
          end
        end
        CHECK: begin
          if (w_chk_sum > CHK_MAX) begin
            w_state_nxt = SLIP;
          end else if (r_chk_cnt == CHK_LAST) begin
            w_state_nxt    = LOCKED;
            w_win_cnt_nxt  = '0;
            w_loss_err_nxt = '0;
          end else begin
            w_chk_cnt_nxt = r_chk_cnt + CW'(1);
            w_chk_err_nxt = w_chk_sum[EW-1:0];
          end
        end
        default: begin
          // Loss of lock re-settles on the same phase; a later CHECK failure does the slipping.
          if (w_loss_sum >= LOSS_MAX) begin
            w_state_nxt     = SETTLE;
            w_set_cnt_nxt   = '0;
            w_lock_lost_nxt = 1'b1;
          end else if (r_win_cnt == WIN_LAST) begin
            w_win_cnt_nxt  = '0;
            w_loss_err_nxt = '0;
          end else begin
            w_win_cnt_nxt  = r_win_cnt + WW'(1);
            w_loss_err_nxt = w_loss_sum[LW-1:0];
          end
        end
      endcase
    end

    w_locked_nxt = (w_state_nxt == LOCKED);
  end

  always_ff @(posedge clk80 or posedge reset) begin
    if (reset) begin
      r_state      <= SETTLE;
      r_set_cnt    <= '0;
      r_chk_cnt    <= '0;
      r_chk_err    <= '0;
      r_win_cnt    <= '0;
      r_loss_err   <= '0;
      r_phase      <= 3'd0;
      r_slip_count <= 8'd0;
      r_locked     <= 1'b0;
      r_slip_pulse <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_set_cnt    <= w_set_cnt_nxt;
      r_chk_cnt    <= w_chk_cnt_nxt;
      r_chk_err    <= w_chk_err_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_loss_err   <= w_loss_err_nxt;
      r_phase      <= w_phase_nxt;
      r_slip_count <= w_slip_count_nxt;
      r_locked     <= w_locked_nxt;
      r_slip_pulse <= w_slip_pulse_nxt;
      r_lock_lost  <= w_lock_lost_nxt;
    end
  end

  assign bus.phase      = r_phase;
  assign bus.locked     = r_locked;
  assign bus.slip_pulse = r_slip_pulse;
  assign bus.lock_lost  = r_lock_lost;
  assign bus.slip_count = r_slip_count;
endmodule

// File: tb/tb_nrzi_symbol_aligner.sv
// Bench for nrzi_symbol_aligner: time-stamped error-history model compared every cycle,
// directed scenarios pinned with hand-computed values, then randomized traffic.
module tb_nrzi_symbol_aligner;
  localparam int SETTLE_CYCLES = 4;
  localparam int CHECK_LEN     = 64;
  localparam int LOCK_ERR_MAX  = 0;
  localparam int LOSS_WINDOW   = 256;
  localparam int LOSS_ERR_MAX  = 4;

  localparam int M_IDLE = 0, M_SETTLE = 1, M_CHECK = 2, M_SLIP = 3, M_LOCKED = 4;

  logic clk80 = 1'b0;
  logic reset;

  nrzi_symbol_aligner_if bus ();

  nrzi_symbol_aligner #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CHECK_LEN     (CHECK_LEN),
    .LOCK_ERR_MAX  (LOCK_ERR_MAX),
    .LOSS_WINDOW   (LOSS_WINDOW),
    .LOSS_ERR_MAX  (LOSS_ERR_MAX)
  ) dut (
    .clk80 (clk80),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #6 clk80 = ~clk80;

  int n_cmp = 0;
  int n_bad = 0;
  int lost_seen = 0;
  int pulse_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: segments are time stamps into the dec_error history; error
  // counts are recomputed as plain sums over the relevant span of history.
  bit   hist[$];
  int   m_mode, m_seg, m_phase, m_slips;
  bit   m_fresh;
  logic m_locked, m_pulse, m_lost;

  function automatic int errs_between(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i <= to; i++) n += int'(hist[i]);
    return n;
  endfunction

  always @(posedge clk80 or posedge reset) begin
    if (reset) begin
      m_mode = M_SETTLE; m_fresh = 1'b1; m_phase = 0; m_slips = 0;
      m_locked = 1'b0; m_pulse = 1'b0; m_lost = 1'b0;
    end else begin
      int t;
      int w0;
      t = hist.size();
      hist.push_back(bus.dec_error);
      if (m_fresh) begin m_seg = t; m_fresh = 1'b0; end
      m_pulse = 1'b0;
      m_lost  = 1'b0;
      if (m_mode == M_SLIP && bus.enable) begin
        m_phase = (m_phase + 1) % 5;
        m_pulse = 1'b1;
        if (m_slips < 255) m_slips++;
      end
      if (!bus.enable) m_mode = M_IDLE;
      else if (bus.force_slip && m_mode != M_IDLE) m_mode = M_SLIP;
      else begin
        case (m_mode)
          M_IDLE, M_SLIP: begin m_mode = M_SETTLE; m_seg = t + 1; end
          M_SETTLE: if (t - m_seg == SETTLE_CYCLES - 1) begin m_mode = M_CHECK; m_seg = t + 1; end
          M_CHECK: begin
            if (errs_between(m_seg, t) > LOCK_ERR_MAX) m_mode = M_SLIP;
            else if (t - m_seg == CHECK_LEN - 1) begin m_mode = M_LOCKED; m_seg = t + 1; end
          end
          default: begin
            w0 = m_seg + ((t - m_seg) / LOSS_WINDOW) * LOSS_WINDOW;
            if (errs_between(w0, t) >= LOSS_ERR_MAX) begin
              m_mode = M_SETTLE; m_seg = t + 1; m_lost = 1'b1;
            end
          end
        endcase
      end
      m_locked = (m_mode == M_LOCKED);
    end
  end

  always @(negedge clk80) begin
    check("phase", int'(bus.phase), m_phase);
    check("locked", int'(bus.locked), int'(m_locked));
    check("slip_pulse", int'(bus.slip_pulse), int'(m_pulse));
    check("lock_lost", int'(bus.lock_lost), int'(m_lost));
    check("slip_count", int'(bus.slip_count), m_slips);
    if (bus.lock_lost === 1'b1) lost_seen++;
    if (bus.slip_pulse === 1'b1) pulse_seen++;
  end

  int err_mode = 0;   // 0 manual, 1 error unless phase 2, 2 random per mille
  int err_pm = 0;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk80);
      #1;
      if (err_mode == 1) bus.dec_error = (m_phase != 2);
      else if (err_mode == 2) bus.dec_error = (int'($urandom_range(999)) < err_pm);
    end
  endtask

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    while (bus.locked !== 1'b1 && n < 3000) begin tick(1); n++; end
    check({name, "_lock_reached"}, int'(bus.locked), 1);
  endtask

  task automatic wait_chk(input int idx);
    int n;
    n = 0;
    while (!(m_mode == M_CHECK && hist.size() - m_seg == idx) && n < 500) begin tick(1); n++; end
    check("reach_check_cycle", int'(n < 500), 1);
  endtask

  int p0, l0;
  int pms[4] = '{0, 3, 30, 400};

  initial begin
    bus.enable = 1'b1; bus.force_slip = 1'b0; bus.dec_error = 1'b0;
    reset = 1'b1;
    tick(3);
    check("rst_phase", int'(bus.phase), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_slip_count", int'(bus.slip_count), 0);
    reset = 1'b0;

    // Clean link: 4 settle + 64 check cycles, locked visible on cycle index 68.
    tick(67);
    check("lock0_not_yet", int'(bus.locked), 0);
    tick(1);
    check("lock0_locked", int'(bus.locked), 1);
    check("lock0_phase", int'(bus.phase), 0);
    check("lock0_slips", int'(bus.slip_count), 0);

    // Four forced slips to phase 4, then hunt 4->0->1->2.
    p0 = pulse_seen; l0 = lost_seen;
    err_mode = 1; bus.force_slip = 1'b1;
    tick(4);
    bus.force_slip = 1'b0;
    wait_lock("hunt");
    check("hunt_phase", int'(bus.phase), 2);
    check("hunt_slips", int'(bus.slip_count), 7);
    check("hunt_pulses", pulse_seen - p0, 7);
    check("hunt_no_lost", lost_seen - l0, 0);

    // Single error at CHECK cycle 10, then at the final CHECK cycle 63.
    err_mode = 0; bus.dec_error = 1'b0; bus.force_slip = 1'b1;
    tick(1);
    bus.force_slip = 1'b0;
    wait_chk(10);
    bus.dec_error = 1'b1; tick(1); bus.dec_error = 1'b0;
    check("abort10_in_slip", int'(bus.slip_pulse), 0);
    tick(1);
    check("abort10_pulse", int'(bus.slip_pulse), 1);
    check("abort10_phase", int'(bus.phase), 4);
    check("abort10_slips", int'(bus.slip_count), 9);
    wait_chk(63);
    bus.dec_error = 1'b1; tick(1); bus.dec_error = 1'b0;
    check("tie63_not_locked", int'(bus.locked), 0);
    tick(1);
    check("tie63_pulse", int'(bus.slip_pulse), 1);
    check("tie63_phase", int'(bus.phase), 0);
    check("tie63_slips", int'(bus.slip_count), 10);
    wait_lock("relock0");

    // Ten windows of three errors each (one on the window's last cycle) keep lock.
    l0 = lost_seen;
    for (int c = 0; c < 10 * LOSS_WINDOW; c++) begin
      int pos;
      pos = (hist.size() - m_seg) % LOSS_WINDOW;
      bus.dec_error = (pos == 50 || pos == 150 || pos == LOSS_WINDOW - 1);
      tick(1);
    end
    bus.dec_error = 1'b0;
    check("win3_locked", int'(bus.locked), 1);
    check("win3_no_lost", lost_seen - l0, 0);
    bus.dec_error = 1'b1;
    tick(3);
    check("loss3_still_locked", int'(bus.locked), 1);
    tick(1);
    bus.dec_error = 1'b0;
    check("loss4_lost", int'(bus.lock_lost), 1);
    check("loss4_unlocked", int'(bus.locked), 0);
    check("loss4_phase", int'(bus.phase), 0);
    tick(1);
    check("loss4_one_cycle", int'(bus.lock_lost), 0);
    wait_lock("after_loss");
    check("after_loss_slips", int'(bus.slip_count), 10);

    // Controls: force_slip out of LOCKED, enable drop, force_slip while disabled.
    l0 = lost_seen;
    bus.force_slip = 1'b1; tick(1); bus.force_slip = 1'b0; tick(1);
    check("fslip_phase", int'(bus.phase), 1);
    check("fslip_slips", int'(bus.slip_count), 11);
    check("fslip_no_lost", lost_seen - l0, 0);
    wait_lock("after_force");
    bus.enable = 1'b0; tick(1);
    check("idle_unlocked", int'(bus.locked), 0);
    tick(3);
    check("idle_phase_held", int'(bus.phase), 1);
    bus.force_slip = 1'b1; tick(2); bus.force_slip = 1'b0;
    check("idle_fslip_slips", int'(bus.slip_count), 11);
    check("idle_fslip_phase", int'(bus.phase), 1);
    bus.enable = 1'b1;
    wait_lock("after_idle");

    // Randomized traffic at several error rates with sporadic controls.
    err_mode = 2;
    for (int blk = 0; blk < 8; blk++) begin
      err_pm = pms[blk % 4];
      for (int c = 0; c < 500; c++) begin
        bus.force_slip = ($urandom_range(199) == 0);
        bus.enable     = ($urandom_range(299) != 0);
        tick(1);
      end
    end
    err_mode = 0; bus.dec_error = 1'b0; bus.force_slip = 1'b0; bus.enable = 1'b1;
    tick(2);

    // Saturation, then reset asserted in the middle of a SLIP cycle.
    bus.force_slip = 1'b1;
    tick(300);
    check("sat_slips", int'(bus.slip_count), 255);
    #2 reset = 1'b1;
    #1;
    check("rst_slip_phase", int'(bus.phase), 0);
    check("rst_slip_locked", int'(bus.locked), 0);
    check("rst_slip_pulse", int'(bus.slip_pulse), 0);
    check("rst_slip_lost", int'(bus.lock_lost), 0);
    check("rst_slip_count", int'(bus.slip_count), 0);
    bus.force_slip = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
